stop_it_controller: RTL
=======================

Name: stop_it_controller

Overview:
- Game-control FSM for the Stop It game; sits directly downstream of the 5-bit time counter and drives that counter's enable and reset.
- Latches a pseudo-random target on the start button, waits an arming delay, then runs the counter.
- Grades the stop button press against the live count.
- Drives win/lose indication and a win-streak count to the display logic.

Parameters:
ARM_TICKS, 8, clk_4_i cycles spent in ARMED before counting starts (legal 1..32; 8 = 2 s)
RESULT_TICKS, 16, clk_4_i cycles WON/LOST is held before returning to IDLE (legal 1..32; 16 = 4 s)

Ports:
clk_4_i  input  1  4 Hz game clock; sole clock
rst_ni  input  1  reset, asynchronous, active-low
start_i  input  1  start button level, already synchronised and debounced to clk_4_i
stop_i  input  1  stop button level, already synchronised and debounced to clk_4_i
target_i  input  5  free-running random value from the LFSR
count_i  input  5  current count from the time counter
timer_en_o  output  1  time-counter enable
timer_rst_no  output  1  time-counter synchronous clear, active-low
target_o  output  5  latched target for display
phase_o  output  3  current state encoding (package enum)
win_o  output  1  high while in WON
lose_o  output  1  high while in LOST
streak_o  output  4  consecutive-win count

Behaviour:
- Reset (async assert, no clock edge required):
  - state=IDLE, target_o=0, streak_o=0, wait counter=0.
  - timer_en_o=0, timer_rst_no=0, win_o=0, lose_o=0.
  - Both edge-detector history flops set to 1, so a button held through reset release does not produce an edge.
- Button edges: start_rise = start_i & ~start_prev (same for stop). History flops update every cycle. An edge is visible in the cycle start_i first reads 1.
- All outputs are registered or decoded directly from registered state. There are no combinational paths from inputs to outputs.
- IDLE:
  - timer_en_o=0, timer_rst_no=0.
  - On start_rise: target_q<=target_i, wait<=0, next=ARMED.
  - stop_rise is ignored.
- ARMED:
  - timer_en_o=0, timer_rst_no=0. Wait counter increments each cycle.
  - When wait==ARM_TICKS-1: next=RUN.
  - start_rise and stop_rise are ignored.
- RUN: timer_en_o=1, timer_rst_no=1. Decision priority within a cycle:
  1. stop_rise with count_i==target_q: next=WON; streak<=streak+1, saturating at 15.
  2. stop_rise with count_i!=target_q: next=LOST; streak<=0.
  3. No stop_rise and count_i==31 (overrun, counter would wrap): next=LOST; streak<=0.
  - In all three cases wait<=0.
  - A stop in the count_i==31 cycle is graded, not treated as overrun. Stop takes priority.
  - start_rise is ignored.
- WON / LOST:
  - timer_en_o=0, timer_rst_no=1, so the counter freezes and the final time stays on display.
  - win_o=1 in WON; lose_o=1 in LOST.
  - Wait counter increments; when wait==RESULT_TICKS-1, next=IDLE.
  - Button edges are ignored.
- Returning to IDLE re-clears the counter via timer_rst_no=0. target_o holds its value until the next start.
- Wait counter width is $clog2(32+1)=6 bits; the wait counter never wraps.
- The counter sees its enable one cycle after RUN is entered, so the first RUN cycle observes count_i=0.
- Reset mid-game: immediate return to the reset values above; streak is lost.

Decomposition:
- stop_it_pkg:
  - phase_e enum, 3-bit: IDLE=0, ARMED=1, RUN=2, WON=3, LOST=4.
  - TIME_W=5, STREAK_W=4, STREAK_MAX=15.
- One sub-module, rise_detect: one history flop plus AND. Parameter RESET_VAL, default 1. Instantiated twice, for start and stop.

Test Plan:
1. Hold start_i=1 across reset release -> phase stays IDLE. Release start, then press with target_i=12 -> next cycle phase=ARMED, target_o=12; a target_i change afterwards does not affect target_o.
2. Win: from ARMED, after 8 cycles phase=RUN, timer_en_o=1, timer_rst_no=1. Behavioural counter model runs; stop_rise when count_i=12 -> next cycle phase=WON, win_o=1, streak_o=1, timer_en_o=0. After 16 cycles phase=IDLE, timer_rst_no=0.
3. Lose and streak clear: streak_o=3, target 20, stop at count_i=19 -> phase=LOST, lose_o=1, streak_o=0.
4. Overrun and priority:
   - No stop, count_i reaches 31 -> next cycle LOST, timer_en_o=0.
   - Separate run with target 31, stop_rise at count_i=31 -> WON.
5. Streak saturation: 16 consecutive wins -> streak_o=15 after the 15th and 16th win. Start/stop edges injected during ARMED, WON and LOST change nothing.
6. Assert rst_ni low mid-RUN between clock edges -> all outputs at reset values immediately, before the next posedge; phase_o=IDLE.

Source files
------------

// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop It game controller.
package stop_it_pkg;

  // Game phase, also exported on phase_o for display and debug.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } phase_e;

  localparam int TIME_W   = 5;
  localparam int STREAK_W = 4;
  // Wait counter covers up to 32 ticks without wrapping.
  localparam int WAIT_W   = $clog2(32 + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = 4'd15;
  localparam logic [TIME_W-1:0]   TIME_MAX   = '1;

endpackage

// File: rtl/stop_it_controller_if.sv
// Signal bundle between the game controller and its surroundings
// (buttons, LFSR, time counter, display).
// There is no valid/ready handshake here: buttons are synchronised,
// debounced levels and every other signal is a level sampled each clk_4_i
// cycle; the controller derives single-cycle press events internally.
interface stop_it_controller_if;
  logic       start_i;
  logic       stop_i;
  logic [4:0] target_i;
  logic [4:0] count_i;
  logic       timer_en_o;
  logic       timer_rst_no;
  logic [4:0] target_o;
  logic [2:0] phase_o;
  logic       win_o;
  logic       lose_o;
  logic [3:0] streak_o;

  // Environment side: drives buttons, random target and live count.
  modport master (
    output start_i, stop_i, target_i, count_i,
    input  timer_en_o, timer_rst_no, target_o, phase_o, win_o, lose_o, streak_o
  );

  // Controller side.
  modport slave (
    input  start_i, stop_i, target_i, count_i,
    output timer_en_o, timer_rst_no, target_o, phase_o, win_o, lose_o, streak_o
  );
endinterface

// File: rtl/stop_it_controller_rise_detect.sv
// Rising-edge detector for a synchronised button level. The history flop
// resets to RESET_VAL so that a button held through reset release does not
// look like a fresh press.
module rise_detect #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;

  // History flop: previous cycle's level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/stop_it_controller.sv
// Stop It game controller: latches a random target on start, waits an
// arming delay, runs the time counter and grades the stop press against
// the live count. Drives win/lose and a saturating win streak.
module stop_it_controller
  import stop_it_pkg::*;
#(
  parameter int ARM_TICKS    = 8,
  parameter int RESULT_TICKS = 16
) (
  input  logic                 clk_4_i,
  input  logic                 rst_ni,
  stop_it_controller_if.slave  bus
);

  localparam logic [WAIT_W-1:0] ARM_LAST    = WAIT_W'(ARM_TICKS - 1);
  localparam logic [WAIT_W-1:0] RESULT_LAST = WAIT_W'(RESULT_TICKS - 1);

  phase_e                state_q, state_d;
  logic [TIME_W-1:0]     target_q, target_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  start_rise;
  logic                  stop_rise;

  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk   (clk_4_i),
    .rst_n (rst_ni),
    .level (bus.start_i),
    .rise  (start_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_stop_rise (
    .clk   (clk_4_i),
    .rst_n (rst_ni),
    .level (bus.stop_i),
    .rise  (stop_rise)
  );

  // State, target, streak and wait-counter registers.
  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      target_q <= '0;
      streak_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      streak_q <= streak_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state logic: phase sequencing and grading of the stop press.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    streak_d = streak_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          target_d = bus.target_i;
          wait_d   = '0;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (wait_q == ARM_LAST) begin
          wait_d  = '0;
          state_d = RUN;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RUN: begin
        // A stop in the final count cycle is graded, not an overrun.
        if (stop_rise) begin
          wait_d = '0;
          if (bus.count_i == target_q) begin
            state_d  = WON;
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                : streak_q + STREAK_W'(1);
          end else begin
            state_d  = LOST;
            streak_d = '0;
          end
        end else if (bus.count_i == TIME_MAX) begin
          wait_d   = '0;
          state_d  = LOST;
          streak_d = '0;
        end
      end
      WON, LOST: begin
        if (wait_q == RESULT_LAST) begin
          wait_d  = '0;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs decode registered state only; the counter is held clear in
  // IDLE/ARMED and frozen (not cleared) in WON/LOST so the time stays shown.
  assign bus.timer_en_o   = (state_q == RUN);
  assign bus.timer_rst_no = (state_q == RUN) || (state_q == WON) || (state_q == LOST);
  assign bus.win_o        = (state_q == WON);
  assign bus.lose_o       = (state_q == LOST);
  assign bus.phase_o      = state_q;
  assign bus.target_o     = target_q;
  assign bus.streak_o     = streak_q;

endmodule
